// File: rtl/haze_out_axis_bridge.sv
// Output bridge from the haze-removal pixel stream to AXI4-Stream video.
// Pixels are tagged with start-of-frame / end-of-line flags and queued in a
// FIFO, which absorbs downstream backpressure because the upstream cannot
// stall. A full FIFO drops the rest of the frame until the next vsync.
//
// Handshake: a beat transfers on any rising clk edge where m_axis_tvalid and
// m_axis_tready are both 1; once tvalid is raised it stays high and
// tdata/tuser/tlast stay stable until that transfer happens.
module haze_out_axis_bridge #(
    parameter int PIC_WIDTH  = 640,
    parameter int FIFO_DEPTH = 1024,
    parameter int RB_SWAP    = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pre_frame_vsync,
    input  logic                          pre_frame_href,
    input  logic                          pre_frame_clken,
    input  logic [23:0]                   pre_img,
    output logic [23:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          overflow,
    output logic                          line_err,
    output logic [15:0]                   frame_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {WAIT_SOF, PASS, DROP} state_t;

    state_t          state_q, state_d;
    logic            vsync_d1_q, href_d1_q;
    logic [CW-1:0]   col_q, col_d;
    logic            sof_pend_q, sof_pend_d;
    logic            overflow_q, overflow_d;
    logic            line_err_q, line_err_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;

    logic [25:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     mem_cnt_q;
    logic            out_valid_q;
    logic [25:0]     out_data_q;

    logic            qp, vs_rise, href_fall, full, wr_en, load;
    logic            eff_sof;
    logic [CW-1:0]   eff_col;
    state_t          eff_state;
    logic [23:0]     pix;
    logic [25:0]     wr_entry;

    assign qp        = pre_frame_clken & pre_frame_href;
    assign vs_rise   = pre_frame_vsync & ~vsync_d1_q;
    assign href_fall = href_d1_q & ~pre_frame_href;
    assign pix       = (RB_SWAP != 0) ? {pre_img[7:0], pre_img[15:8], pre_img[23:16]} : pre_img;

    // Level includes the output register; full is judged on the registered level.
    assign fifo_level = mem_cnt_q + {{AW{1'b0}}, out_valid_q};
    assign full       = (fifo_level == LVL_FULL);

    // A vsync rise takes effect in the same cycle, so a coincident pixel joins the new frame.
    assign eff_state = vs_rise ? PASS : state_q;
    assign eff_col   = vs_rise ? '0 : col_q;
    assign eff_sof   = vs_rise | sof_pend_q;
    assign wr_entry  = {eff_sof, (eff_col == COL_LAST), pix};

    // Output register refills from memory whenever it is empty or being consumed.
    assign load = (mem_cnt_q != '0) & (~out_valid_q | m_axis_tready);

    // Frame FSM, column tracking and status next-state logic.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        sof_pend_d  = sof_pend_q;
        overflow_d  = overflow_q;
        line_err_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;
        wr_en       = 1'b0;
        if (vs_rise) begin
            state_d    = PASS;
            col_d      = '0;
            sof_pend_d = 1'b1;
            overflow_d = 1'b0;
        end
        // Short line: keep the partial line, restart the column count.
        if (href_fall && (col_q != '0)) begin
            line_err_d = 1'b1;
            col_d      = '0;
        end
        if (qp && (eff_state == PASS)) begin
            col_d = (eff_col == COL_LAST) ? '0 : eff_col + 1'b1;
            if (full) begin
                overflow_d = 1'b1;
                state_d    = DROP;
            end else begin
                wr_en      = 1'b1;
                sof_pend_d = 1'b0;
                if (eff_sof) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
        end
    end

    // Frame FSM and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_SOF;
            vsync_d1_q  <= 1'b0;
            href_d1_q   <= 1'b0;
            col_q       <= '0;
            sof_pend_q  <= 1'b0;
            overflow_q  <= 1'b0;
            line_err_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            vsync_d1_q  <= pre_frame_vsync;
            href_d1_q   <= pre_frame_href;
            col_q       <= col_d;
            sof_pend_q  <= sof_pend_d;
            overflow_q  <= overflow_d;
            line_err_q  <= line_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    // FIFO pointers, memory occupancy and the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (load) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, load})
                2'b10:   mem_cnt_q <= mem_cnt_q + 1'b1;
                2'b01:   mem_cnt_q <= mem_cnt_q - 1'b1;
                default: mem_cnt_q <= mem_cnt_q;
            endcase
            if (load) begin
                out_data_q  <= mem[rd_ptr_q];
                out_valid_q <= 1'b1;
            end else if (m_axis_tready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tuser  = out_data_q[25];
    assign m_axis_tlast  = out_data_q[24];
    assign m_axis_tdata  = out_data_q[23:0];
    assign overflow      = overflow_q;
    assign line_err      = line_err_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_haze_out_axis_bridge.sv
// Bench for haze_out_axis_bridge: a frame-level reference model predicts the
// beat stream, occupancy and status; directed scenarios add literal checks.
module tb_haze_out_axis_bridge;

    localparam int W = 4;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs = 1'b0, hr = 1'b0, ce = 1'b0;
    logic [23:0] img = '0;
    logic        tready = 1'b0;

    logic [23:0] tdata, sw_tdata;
    logic        tvalid, tuser, tlast, ovf, lerr;
    logic        sw_tvalid, sw_tuser, sw_tlast, sw_ovf, sw_lerr;
    logic [15:0] fcnt, sw_fcnt;
    logic [3:0]  level, sw_level;

    haze_out_axis_bridge #(.PIC_WIDTH(W), .FIFO_DEPTH(D), .RB_SWAP(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .pre_frame_vsync(vs), .pre_frame_href(hr), .pre_frame_clken(ce), .pre_img(img),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tuser(tuser), .m_axis_tlast(tlast),
        .overflow(ovf), .line_err(lerr), .frame_cnt(fcnt), .fifo_level(level)
    );

    haze_out_axis_bridge #(.PIC_WIDTH(W), .FIFO_DEPTH(D), .RB_SWAP(1)) dut_sw (
        .clk(clk), .rst_n(rst_n),
        .pre_frame_vsync(vs), .pre_frame_href(hr), .pre_frame_clken(ce), .pre_img(img),
        .m_axis_tdata(sw_tdata), .m_axis_tvalid(sw_tvalid), .m_axis_tready(tready),
        .m_axis_tuser(sw_tuser), .m_axis_tlast(sw_tlast),
        .overflow(sw_ovf), .line_err(sw_lerr), .frame_cnt(sw_fcnt), .fifo_level(sw_level)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level rules, expected beat queue, observed beats.
    logic [25:0] exp_q[$];
    logic [25:0] obs_q[$];
    int          m_lvl, m_col, lerr_cnt;
    logic        m_acc, m_sof, m_ovf, m_lerr, m_vs_d1, m_hr_d1;
    logic [15:0] m_fcnt;
    logic        prev_stall;
    logic [25:0] prev_word;

    task automatic model_reset();
        exp_q.delete();
        m_lvl = 0; m_col = 0; m_acc = 1'b0; m_sof = 1'b0; m_ovf = 1'b0;
        m_lerr = 1'b0; m_vs_d1 = 1'b0; m_hr_d1 = 1'b0; m_fcnt = '0;
        prev_stall = 1'b0; prev_word = '0;
    endtask

    // Scoreboard: compare on every falling edge, then advance the model
    // for the coming rising edge using the inputs now applied.
    initial begin
        logic qp, vs_rise, hf, pop, wr, full_m, lerr_n;
        logic [25:0] got;
        model_reset();
        lerr_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
                chk("rst_tvalid", 32'(tvalid), 32'd0);
                chk("rst_level", 32'(level), 32'd0);
                chk("rst_status", {29'd0, ovf, lerr, |fcnt}, 32'd0);
            end else begin
                chk("level", 32'(level), 32'(m_lvl));
                chk("overflow", 32'(ovf), 32'(m_ovf));
                chk("frame_cnt", 32'(fcnt), 32'(m_fcnt));
                chk("line_err", 32'(lerr), 32'(m_lerr));
                if (lerr) lerr_cnt++;
                got = {tuser, tlast, tdata};
                if (prev_stall) begin
                    chk("stall_valid", 32'(tvalid), 32'd1);
                    chk("stall_hold", 32'(got), 32'(prev_word));
                end
                if (tvalid && tready) begin
                    obs_q.push_back(got);
                    if (exp_q.size() == 0) begin
                        chk("beat_unexpected", 32'(got), 32'h0);
                        chk("beat_queue_empty", 32'd1, 32'(exp_q.size()));
                    end else begin
                        chk("beat", 32'(got), 32'(exp_q.pop_front()));
                    end
                end
                prev_stall = tvalid & ~tready;
                prev_word  = got;

                qp      = ce & hr;
                vs_rise = vs & ~m_vs_d1;
                hf      = m_hr_d1 & ~hr;
                pop     = tvalid & tready;
                full_m  = (m_lvl >= D);
                lerr_n  = hf && (m_col != 0);
                wr      = 1'b0;
                if (vs_rise) begin
                    m_acc = 1'b1; m_sof = 1'b1; m_col = 0; m_ovf = 1'b0;
                end
                if (lerr_n) m_col = 0;
                if (qp && m_acc) begin
                    if (full_m) begin
                        m_ovf = 1'b1;
                        m_acc = 1'b0;
                    end else begin
                        exp_q.push_back({m_sof, (m_col == W - 1), img});
                        if (m_sof) m_fcnt = m_fcnt + 16'd1;
                        m_sof = 1'b0;
                        wr = 1'b1;
                    end
                    m_col = (m_col + 1) % W;
                end
                m_lvl   = m_lvl + int'(wr) - int'(pop);
                m_lerr  = lerr_n;
                m_vs_d1 = vs;
                m_hr_d1 = hr;
            end
        end
    end

    // Driver tasks
    logic toggle_en = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_en) tready = ~tready;
    endtask

    task automatic idle(input int n);
        vs = 1'b0; hr = 1'b0; ce = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic vs_pulse();
        vs = 1'b1; tick();
        vs = 1'b0; tick();
    endtask

    task automatic send_line(input int n, input int base);
        hr = 1'b1;
        for (int i = 0; i < n; i++) begin
            ce = 1'b1;
            img = 24'(base + i);
            tick();
        end
        ce = 1'b0;
        hr = 1'b0;
        tick();
    endtask

    logic [25:0] want [8];

    task automatic check_beats(input string name, input int n);
        chk({name, "_count"}, 32'(obs_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < obs_q.size()) chk(name, 32'(obs_q[i]), 32'(want[i]));
        end
    endtask

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Normal frame, tready held high, with latency checks on the first pixel.
        tready = 1'b1;
        obs_q.delete();
        vs_pulse();
        hr = 1'b1;
        for (int i = 0; i < W; i++) begin
            ce = 1'b1;
            img = 24'(1 + i);
            @(negedge clk);
            if (i == 1) chk("latency_n1_tvalid", 32'(tvalid), 32'd0);
            if (i == 2) chk("latency_n2_tvalid", 32'(tvalid), 32'd1);
            @(posedge clk);
            #1;
        end
        ce = 1'b0; hr = 1'b0; tick();
        send_line(4, 5);
        idle(6);
        want = '{26'h2000001, 26'h0000002, 26'h0000003, 26'h1000004,
                 26'h0000005, 26'h0000006, 26'h0000007, 26'h1000008};
        check_beats("t1_beats", 8);
        chk("t1_frame_cnt", 32'(fcnt), 32'd1);
        chk("t1_overflow", 32'(ovf), 32'd0);

        // Same frame content with tready toggling every cycle.
        obs_q.delete();
        toggle_en = 1'b1;
        vs_pulse();
        send_line(4, 1);
        send_line(4, 5);
        idle(20);
        toggle_en = 1'b0;
        check_beats("t2_beats", 8);
        chk("t2_frame_cnt", 32'(fcnt), 32'd2);

        // Overflow: 12 pixels into a depth-8 FIFO with tready low.
        tready = 1'b0;
        obs_q.delete();
        vs_pulse();
        send_line(4, 16);
        send_line(4, 20);
        send_line(4, 24);
        chk("t3_overflow", 32'(ovf), 32'd1);
        chk("t3_level", 32'(level), 32'd8);
        chk("t3_frame_cnt", 32'(fcnt), 32'd3);
        tready = 1'b1;
        idle(12);
        send_line(4, 40);
        idle(4);
        want = '{26'h2000010, 26'h0000011, 26'h0000012, 26'h1000013,
                 26'h0000014, 26'h0000015, 26'h0000016, 26'h1000017};
        check_beats("t3_beats", 8);
        chk("t3_overflow_sticky", 32'(ovf), 32'd1);
        vs_pulse();
        chk("t3_overflow_clear", 32'(ovf), 32'd0);
        obs_q.delete();
        send_line(4, 50);
        idle(6);
        want = '{26'h2000032, 26'h0000033, 26'h0000034, 26'h1000035, 0, 0, 0, 0};
        check_beats("t3_resync", 4);

        // Short line then a full line.
        obs_q.delete();
        vs_pulse();
        lerr_cnt = 0;
        send_line(3, 60);
        send_line(4, 70);
        idle(6);
        chk("t4_line_err_cycles", 32'(lerr_cnt), 32'd1);
        want = '{26'h200003C, 26'h000003D, 26'h000003E, 26'h0000046,
                 26'h0000047, 26'h0000048, 26'h1000049, 0};
        check_beats("t4_beats", 7);
        chk("t4_frame_cnt", 32'(fcnt), 32'd5);

        // Byte swap on the second instance.
        vs_pulse();
        hr = 1'b1; ce = 1'b1; img = 24'h112233;
        tick();
        hr = 1'b0; ce = 1'b0;
        begin
            int k;
            k = 0;
            while (k < 10) begin
                @(negedge clk);
                if (tvalid) break;
                k++;
            end
            chk("t5_tvalid", 32'(tvalid), 32'd1);
            chk("t5_noswap", 32'(tdata), 32'h112233);
            chk("t5_swap", 32'(sw_tdata), 32'h332211);
        end
        @(posedge clk); #1;
        idle(4);

        // Reset mid-frame with 5 entries queued.
        tready = 1'b0;
        vs_pulse();
        hr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ce = 1'b1;
            img = 24'(80 + i);
            tick();
        end
        ce = 1'b0; hr = 1'b0;
        tick(); tick();
        chk("t6_level_before", 32'(level), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", 32'(tvalid), 32'd0);
        chk("t6_rst_level", 32'(level), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tready = 1'b1;
        obs_q.delete();
        tick();
        send_line(4, 90);
        idle(6);
        chk("t6_ignored_count", 32'(obs_q.size()), 32'd0);
        vs_pulse();
        send_line(4, 100);
        idle(6);
        want = '{26'h2000064, 26'h0000065, 26'h0000066, 26'h1000067, 0, 0, 0, 0};
        check_beats("t6_beats", 4);
        chk("t6_frame_cnt", 32'(fcnt), 32'd1);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
